// File: rtl/ps2_arrow_decoder.sv
// rtl/ps2_arrow_decoder.sv - PS/2 receiver decoding arrow-key make/break into btnstate
// Define WASD_EN to also map the W/S/A/D scan codes onto the four directions.

module ps2_arrow_decoder #(
   parameter int         TIMEOUT_CYCLES = 5000,
   parameter logic [3:0] IDLE_CODE      = 4'b1111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] btnstate,
   output logic       key_valid,
   output logic       frame_err
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_t;

   rx_state_t     state, next_state;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_prev;
   logic          fall, din;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic [TW-1:0] tmo_cnt;
   logic          byte_ok, byte_bad, timeout;
   logic          byte_ready;
   logic [7:0]    rx_byte;
   logic          ext, brk;
   logic          map_hit;
   logic [1:0]    map_dir;

   assign din  = data_sync[1];
   assign fall = clk_prev & ~clk_sync[1];

   // Lines idle high, so reset the synchronisers high to avoid a phantom edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_prev  <= clk_sync[1];
      end
   end

   always_comb begin
      next_state = state;
      byte_ok    = 1'b0;
      byte_bad   = 1'b0;
      timeout    = 1'b0;
      if (state != S_IDLE && !fall && tmo_cnt == TMO_LAST) begin
         timeout    = 1'b1;
         next_state = S_IDLE;
      end else if (fall) begin
         case (state)
            S_IDLE:   if (!din) next_state = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) next_state = S_PARITY;
            S_PARITY: next_state = S_STOP;
            S_STOP: begin
               next_state = S_IDLE;
               if (din && (^{shift_reg, parity_bit}))
                  byte_ok = 1'b1;
               else
                  byte_bad = 1'b1;
            end
            default:  next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'd0;
         parity_bit <= 1'b0;
         tmo_cnt    <= '0;
         byte_ready <= 1'b0;
         rx_byte    <= 8'd0;
         frame_err  <= 1'b0;
      end else begin
         state      <= next_state;
         byte_ready <= byte_ok;
         frame_err  <= byte_bad | timeout;
         if (byte_ok)
            rx_byte <= shift_reg;
         if (fall || timeout || state == S_IDLE)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TW'(1);
         if (fall && !timeout) begin
            case (state)
               S_IDLE:   bit_cnt <= 3'd0;
               S_DATA: begin
                  shift_reg <= {din, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
               S_PARITY: parity_bit <= din;
               default:  ;
            endcase
         end
      end
   end

   // Direction index doubles as the low two bits of the btnstate code.
   always_comb begin
      map_hit = 1'b0;
      map_dir = 2'd0;
      if (ext) begin
         case (rx_byte)
            8'h75:   begin map_hit = 1'b1; map_dir = 2'd0; end
            8'h72:   begin map_hit = 1'b1; map_dir = 2'd1; end
            8'h6B:   begin map_hit = 1'b1; map_dir = 2'd2; end
            8'h74:   begin map_hit = 1'b1; map_dir = 2'd3; end
            default: ;
         endcase
      end
`ifdef WASD_EN
      else begin
         case (rx_byte)
            8'h1D:   begin map_hit = 1'b1; map_dir = 2'd0; end
            8'h1B:   begin map_hit = 1'b1; map_dir = 2'd1; end
            8'h1C:   begin map_hit = 1'b1; map_dir = 2'd2; end
            8'h23:   begin map_hit = 1'b1; map_dir = 2'd3; end
            default: ;
         endcase
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btnstate  <= IDLE_CODE;
         key_valid <= 1'b0;
         ext       <= 1'b0;
         brk       <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (byte_ready) begin
            if (rx_byte == 8'hE0) begin
               ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (map_hit) begin
                  if (!brk && btnstate != {2'b00, map_dir}) begin
                     btnstate  <= {2'b00, map_dir};
                     key_valid <= 1'b1;
                  end else if (brk && btnstate == {2'b00, map_dir}) begin
                     btnstate  <= IDLE_CODE;
                     key_valid <= 1'b1;
                  end
               end
            end
         end
         if (byte_bad || timeout) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// tb/tb_ps2_arrow_decoder.sv - self-checking bench for ps2_arrow_decoder
// Byte-level reference model plus per-cycle output compare.

module tb_ps2_arrow_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [3:0] btnstate;
   logic       key_valid;
   logic       frame_err;

   localparam logic [7:0] ARROW [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
   localparam logic [7:0] WASD  [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};

   always #5 clk = ~clk;

   ps2_arrow_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .btnstate  (btnstate),
      .key_valid (key_valid),
      .frame_err (frame_err)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [3:0] exp_btn = 4'hF;
   bit         exp_kv = 1'b0;
   bit         exp_fe = 1'b0;
   bit         fe_dc = 1'b0;
   bit         cmp_en = 1'b0;
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   int         kv_pulses = 0;
   int         fe_pulses = 0;
   int         fe_last_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cmp_en) begin
         checks++;
         if (btnstate !== exp_btn) begin
            errors++;
            $display("FAIL btnstate cyc=%0d got %b want %b", cyc, btnstate, exp_btn);
         end
         checks++;
         if (key_valid !== exp_kv) begin
            errors++;
            $display("FAIL key_valid cyc=%0d got %b want %b", cyc, key_valid, exp_kv);
         end
         if (!fe_dc) begin
            checks++;
            if (frame_err !== exp_fe) begin
               errors++;
               $display("FAIL frame_err cyc=%0d got %b want %b", cyc, frame_err, exp_fe);
            end
         end
         if (key_valid === 1'b1) kv_pulses++;
         if (frame_err === 1'b1) begin
            fe_pulses++;
            fe_last_cyc = cyc;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int map_dir(input bit e, input logic [7:0] c);
      for (int i = 0; i < 4; i++) begin
         if (e && c == ARROW[i]) return i;
`ifdef WASD_EN
         if (!e && c == WASD[i]) return i;
`endif
      end
      return -1;
   endfunction

   task automatic model_apply(input logic [7:0] c);
      int d;
      if (c == 8'hE0) begin
         m_ext = 1'b1;
      end else if (c == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         d = map_dir(m_ext, c);
         if (d >= 0) begin
            if (!m_brk) begin
               if (exp_btn != 4'(d)) begin
                  exp_btn = 4'(d);
                  exp_kv  = 1'b1;
               end
            end else if (exp_btn == 4'(d)) begin
               exp_btn = 4'hF;
               exp_kv  = 1'b1;
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   // 40-cycle bit period; stop-bit effects land 3 (error) / 4 (key) cycles after the raw falling edge.
   task automatic send_byte(input logic [7:0] b, input bit bad);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_data = bits[i];
         tick(20);
         ps2_clk = 1'b0;
         if (i == 10) begin
            tick(3);
            if (bad) begin
               exp_fe = 1'b1;
               m_ext  = 1'b0;
               m_brk  = 1'b0;
            end
            tick(1);
            exp_fe = 1'b0;
            if (!bad) model_apply(b);
            tick(1);
            exp_kv = 1'b0;
            tick(15);
         end else begin
            tick(20);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits, output int fall_cyc);
      fall_cyc = 0;
      for (int i = 0; i <= nbits; i++) begin
         ps2_data = (i == 0) ? 1'b0 : b[i-1];
         tick(20);
         ps2_clk  = 1'b0;
         fall_cyc = cyc;
         tick(20);
         ps2_clk  = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic do_reset();
      cmp_en = 1'b0;
      rst_n  = 1'b0;
      tick(3);
      rst_n   = 1'b1;
      exp_btn = 4'hF;
      exp_kv  = 1'b0;
      exp_fe  = 1'b0;
      m_ext   = 1'b0;
      m_brk   = 1'b0;
      cmp_en  = 1'b1;
   endtask

   initial begin
      int k;
      int kv0;
      int fe0;
      int r;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rst_n    = 1'b0;
      tick(3);
      chk("reset_btnstate", int'(btnstate), 4'b1111);
      chk("reset_key_valid", int'(key_valid), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      tick(5);

      kv0 = kv_pulses;
      send_byte(8'hE0, 0); send_byte(8'h6B, 0);
      chk("left_make", int'(btnstate), 4'b0010);
      send_byte(8'hE0, 0); send_byte(8'h6B, 0);
      chk("typematic_kv", kv_pulses - kv0, 1);
      send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
      chk("left_break", int'(btnstate), 4'b1111);
      chk("left_kv", kv_pulses - kv0, 2);

      send_byte(8'hE0, 0); send_byte(8'h75, 0);
      send_byte(8'hE0, 0); send_byte(8'h74, 0);
      chk("overlap_right", int'(btnstate), 4'b0011);
      send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
      chk("overlap_up_rel", int'(btnstate), 4'b0011);
      send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h74, 0);
      chk("overlap_right_rel", int'(btnstate), 4'b1111);

      fe0 = fe_pulses;
      send_byte(8'hE0, 1); send_byte(8'h75, 0);
      chk("parity_fe", fe_pulses - fe0, 1);
      chk("parity_btn", int'(btnstate), 4'b1111);

      fe0 = fe_pulses;
      fe_dc = 1'b1;
      send_partial(8'h5A, 3, k);
      tick(5200);
      fe_dc = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      chk("timeout_fe", fe_pulses - fe0, 1);
      chk("timeout_when", int'((fe_last_cyc - k) >= 4980 && (fe_last_cyc - k) <= 5020), 1);
      send_byte(8'hE0, 0); send_byte(8'h72, 0);
      chk("after_timeout_down", int'(btnstate), 4'b0001);
      send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h72, 0);

      kv0 = kv_pulses;
      send_byte(8'h1C, 0);
`ifdef WASD_EN
      chk("wasd_a", int'(btnstate), 4'b0010);
      send_byte(8'hF0, 0); send_byte(8'h1C, 0);
      chk("wasd_a_rel", int'(btnstate), 4'b1111);
`else
      chk("wasd_a_ignored", int'(btnstate), 4'b1111);
      chk("wasd_a_kv", kv_pulses - kv0, 0);
`endif

      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 9);
         k = $urandom_range(0, 3);
         if (r <= 5) begin
            send_byte(8'hE0, 0);
            if ($urandom_range(0, 2) == 0) send_byte(8'hF0, 0);
            send_byte(ARROW[k], 0);
         end else if (r <= 7) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'hF0, 0);
            send_byte(WASD[k], 0);
         end else begin
            send_byte(8'($urandom_range(0, 255)), r == 9);
         end
      end

      send_byte(8'hE0, 0);
      send_partial(8'h6B, 2, k);
      do_reset();
      kv0 = kv_pulses;
      send_byte(8'h6B, 0);
      chk("reset_mid_btn", int'(btnstate), 4'b1111);
      chk("reset_mid_kv", kv_pulses - kv0, 0);
      tick(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
